// File: rtl/n_bit_serial_sub_pkg.sv
// n_bit_serial_sub_pkg: shared FSM encodings and default width for the serial subtractor
package n_bit_serial_sub_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int DEFAULT_WIDTH = 4;
endpackage

// File: rtl/n_bit_serial_sub_one_bit_fs.sv
// one_bit_fs: gate-level combinational full subtractor (diff = a^b^b_in, borrow out)
module one_bit_fs (
  input  wire a,
  input  wire b,
  input  wire b_in,
  output wire diff,
  output wire b_out
);
  wire t, na, p, q, r;
  xor x1 (t, a, b);
  xor x2 (diff, t, b_in);
  not n1 (na, a);
  and g1 (p, na, b);
  and g2 (q, na, b_in);
  and g3 (r, b, b_in);
  or  o1 (b_out, p, q, r);
endmodule

// File: rtl/n_bit_serial_sub.sv
// n_bit_serial_sub: bit-serial LSB-first subtractor d = a - b - b_in_initial with start/done handshake
module n_bit_serial_sub
  import n_bit_serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in_initial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             b_out_final
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next;
  logic [CW-1:0]    cnt;
  logic             borrow, diff_bit, borrow_next;
  one_bit_fs u_fs (
    .a(a_sr[0]),
    .b(b_sr[0]),
    .b_in(borrow),
    .diff(diff_bit),
    .b_out(borrow_next)
  );
  // shift form avoids a reversed slice when WIDTH is 1
  assign res_next = (res_sr >> 1) | (WIDTH'(diff_bit) << (WIDTH - 1));
  assign busy = state == RUN || state == DONE;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_sr        <= '0;
      b_sr        <= '0;
      res_sr      <= '0;
      borrow      <= 1'b0;
      cnt         <= '0;
      d           <= '0;
      b_out_final <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sr   <= a;
          b_sr   <= b;
          borrow <= b_in_initial;
          cnt    <= '0;
          state  <= RUN;
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          borrow <= borrow_next;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            d           <= res_next;
            b_out_final <= borrow_next;
            state       <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_n_bit_serial_sub.sv
// tb_n_bit_serial_sub: directed and exhaustive checks for WIDTH=4 and WIDTH=1 instances
module tb_n_bit_serial_sub;
  logic clk = 0, rst = 1;
  logic start4 = 0, bin4 = 0, busy4, done4, bo4;
  logic [3:0] a4 = 0, b4 = 0, d4;
  logic start1 = 0, bin1 = 0, busy1, done1, bo1;
  logic [0:0] a1 = 0, b1 = 0, d1;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  n_bit_serial_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .b_in_initial(bin4),
    .busy(busy4), .done(done4), .d(d4), .b_out_final(bo4)
  );
  n_bit_serial_sub #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .b_in_initial(bin1),
    .busy(busy1), .done(done1), .d(d1), .b_out_final(bo1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // starts from IDLE, waits for done, then one more edge so the DUT is back in IDLE
  task automatic go4(input logic [3:0] x, input logic [3:0] y, input logic bi, output int lat);
    a4 = x; b4 = y; bin4 = bi; start4 = 1;
    step();
    start4 = 0;
    lat = 0;
    while (!done4 && lat < 20) begin
      step();
      lat++;
    end
    step();
  endtask

  task automatic go1(input logic [0:0] x, input logic [0:0] y, input logic bi, output int lat);
    a1 = x; b1 = y; bin1 = bi; start1 = 1;
    step();
    start1 = 0;
    lat = 0;
    while (!done1 && lat < 20) begin
      step();
      lat++;
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1;
    step();
    step();
    total++;
    if ({busy4, done4, d4, bo4} !== 7'd0) $display("FAIL reset4 got %b want 0", {busy4, done4, d4, bo4});
    else passed++;
    total++;
    if ({busy1, done1, d1, bo1} !== 4'd0) $display("FAIL reset1 got %b want 0", {busy1, done1, d1, bo1});
    else passed++;
    rst = 0;
    step();
  endtask

  task automatic test_basic();
    a4 = 9; b4 = 3; bin4 = 0; start4 = 1;
    step();
    start4 = 0;
    total++;
    if (busy4 !== 1 || done4 !== 0) $display("FAIL basic_accept busy=%b done=%b want 1 0", busy4, done4);
    else passed++;
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if (busy4 !== 1 || done4 !== 0) $display("FAIL basic_run%0d busy=%b done=%b want 1 0", i, busy4, done4);
      else passed++;
    end
    step();
    total++;
    if (done4 !== 1 || busy4 !== 1 || d4 !== 4'd6 || bo4 !== 0)
      $display("FAIL basic_done done=%b busy=%b d=%0d bo=%b want 1 1 6 0", done4, busy4, d4, bo4);
    else passed++;
    step();
    total++;
    if (busy4 !== 0 || done4 !== 0) $display("FAIL basic_idle busy=%b done=%b want 0 0", busy4, done4);
    else passed++;
  endtask

  task automatic test_vectors();
    int lat;
    go4(4'd3, 4'd9, 1'b0, lat);
    total++;
    if (d4 !== 4'hA || bo4 !== 1 || lat !== 4) $display("FAIL vec_3m9 d=%h bo=%b lat=%0d want a 1 4", d4, bo4, lat);
    else passed++;
    go4(4'd0, 4'd0, 1'b1, lat);
    total++;
    if (d4 !== 4'hF || bo4 !== 1 || lat !== 4) $display("FAIL vec_0m0b d=%h bo=%b lat=%0d want f 1 4", d4, bo4, lat);
    else passed++;
    go4(4'd15, 4'd15, 1'b0, lat);
    total++;
    if (d4 !== 4'h0 || bo4 !== 0 || lat !== 4) $display("FAIL vec_fmf d=%h bo=%b lat=%0d want 0 0 4", d4, bo4, lat);
    else passed++;
  endtask

  task automatic test_busy_ignore();
    int ndone = 0;
    logic [3:0] dval = 0;
    a4 = 5; b4 = 2; bin4 = 0; start4 = 1;
    step();
    for (int i = 1; i <= 14; i++) begin
      start4 = (i == 2 || i == 5);
      if (start4) begin a4 = 15; b4 = 0; end
      step();
      if (done4) begin ndone++; dval = d4; end
    end
    start4 = 0;
    total++;
    if (ndone !== 1) $display("FAIL ignore_count got %0d want 1", ndone);
    else passed++;
    total++;
    if (dval !== 4'd3 || d4 !== 4'd3) $display("FAIL ignore_d got %0d/%0d want 3", dval, d4);
    else passed++;
    total++;
    if (busy4 !== 0) $display("FAIL ignore_idle busy=%b want 0", busy4);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int lat;
    a4 = 12; b4 = 4; bin4 = 0; start4 = 1;
    step();
    start4 = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    total++;
    if ({busy4, done4, d4, bo4} !== 7'd0) $display("FAIL midrst got %b want 0", {busy4, done4, d4, bo4});
    else passed++;
    go4(4'd7, 4'd1, 1'b0, lat);
    total++;
    if (d4 !== 4'd6 || bo4 !== 0 || lat !== 4) $display("FAIL after_rst d=%0d bo=%b lat=%0d want 6 0 4", d4, bo4, lat);
    else passed++;
  endtask

  task automatic test_hold();
    int n = 0;
    a4 = 1; b4 = 1; bin4 = 0; start4 = 1;
    step();
    start4 = 0;
    while (!done4 && n < 20) begin
      total++;
      if (d4 !== 4'd6 || bo4 !== 0) $display("FAIL hold_run%0d d=%0d bo=%b want 6 0", n, d4, bo4);
      else passed++;
      step();
      n++;
    end
    total++;
    if (done4 !== 1 || d4 !== 4'd0 || n !== 4) $display("FAIL hold_done done=%b d=%0d n=%0d want 1 0 4", done4, d4, n);
    else passed++;
    step();
  endtask

  task automatic test_exhaustive();
    int lat, e;
    for (int bi = 0; bi < 2; bi++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++) begin
          go4(4'(x), 4'(y), 1'(bi), lat);
          e = (x - y - bi) & 31;
          total++;
          if ({bo4, d4} !== 5'(e) || lat !== 4 || done4 !== 0)
            $display("FAIL exh4 %0d-%0d-%0d got %0d lat=%0d done=%b want %0d lat 4 done 0", x, y, bi, {bo4, d4}, lat, done4, e);
          else passed++;
        end
    for (int bi = 0; bi < 2; bi++)
      for (int x = 0; x < 2; x++)
        for (int y = 0; y < 2; y++) begin
          go1(1'(x), 1'(y), 1'(bi), lat);
          e = (x - y - bi) & 3;
          total++;
          if ({bo1, d1} !== 2'(e) || lat !== 1 || done1 !== 0)
            $display("FAIL exh1 %0d-%0d-%0d got %0d lat=%0d done=%b want %0d lat 1 done 0", x, y, bi, {bo1, d1}, lat, done1, e);
          else passed++;
        end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_busy_ignore();
    test_reset_mid();
    test_hold();
    test_exhaustive();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
